factorial_core: RTL and testbench
=================================

FACTORIAL_CORE -- requirements
Module: factorial_core

Interface
REQ-001 Parameter: MAX_N, default 20, is the largest operand whose factorial fits in 64 bits; any larger operand is an overflow.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 fifo_empty  input  1  input FIFO empty flag (data_count==0).
REQ-005 fifo_dout  input  32  input FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 fifo_rd_en  output  1  one-cycle FIFO read request.
REQ-007 result  output  64  factorial of the last operand.
REQ-008 result_valid  output  1  result and overflow are valid.
REQ-009 result_ready  input  1  consumer accepts the result.
REQ-010 overflow  output  1  operand > MAX_N; qualified by result_valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, CALC, DONE, with registered state and a separate next-state process.
REQ-013 IDLE: if fifo_empty==0, assert fifo_rd_en for exactly one cycle and go to WAIT; otherwise stay in IDLE with fifo_rd_en=0.
REQ-014 fifo_rd_en SHALL never be asserted outside IDLE, and never while fifo_empty==1 (no RD_ERROR can be caused by this block).
REQ-015 WAIT: capture n=fifo_dout into cnt (32 bit) and set acc (64 bit) to 1.
REQ-016 WAIT with n<=1: go to DONE with acc=1 and overflow=0.
REQ-017 WAIT with n>MAX_N: go to DONE with acc=0 and overflow=1.
REQ-018 WAIT otherwise: go to CALC with overflow=0.
REQ-019 CALC, each cycle: acc<=acc*cnt (truncated to 64 bits, never truncating for n<=MAX_N) and cnt<=cnt-1.
REQ-020 CALC exits to DONE in the cycle that multiplies by cnt==2, so CALC lasts exactly n-1 cycles.
REQ-021 DONE: result_valid=1, result=acc, and overflow held stable.
REQ-022 DONE with result_ready==1: the transfer completes that edge and the FSM goes to IDLE.
REQ-023 DONE with result_ready==0: stay in DONE holding all outputs; FIFO reads are blocked (backpressure).
REQ-024 Latency, rd_en cycle T to result_valid: T+n+1 for 2<=n<=MAX_N; T+2 for n<=1 or n>MAX_N.
REQ-025 Back-to-back operation: the earliest next fifo_rd_en is the cycle after the DONE handshake, i.e. the first IDLE cycle.
REQ-026 result_ready is ignored outside DONE.
REQ-027 fifo_dout is ignored outside WAIT.
REQ-028 fifo_empty is sampled only in IDLE.
REQ-029 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, fifo_rd_en=0, result=0, result_valid=0, overflow=0, busy=0, acc=0, cnt=0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abandon the operation with no result and no further FIFO read.
REQ-032 The first fifo_rd_en after reset release SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-033 FIFO holds 5, result_ready=1 -> fifo_rd_en pulse at T, result_valid at T+6 with result=120, overflow=0, busy falling at T+7.
REQ-034 Operands 0 then 1 -> each gives result=1, valid at T+2, with exactly one rd_en pulse per operand.
REQ-035 Operands 20 then 21 -> result=2432902008176640000 with overflow=0, then result=0 with overflow=1, the second valid 2 cycles after its rd_en.
REQ-036 Operand 3 with result_ready held 0 for 10 cycles while the FIFO is non-empty -> result=6 stable, no fifo_rd_en, then one handshake and the next read in the following IDLE cycle.
REQ-037 reset_n low during the 3rd CALC cycle of n=8 -> all outputs 0 asynchronously; after release with the FIFO empty, no rd_en and busy=0.
REQ-038 FIFO empty for 50 cycles -> fifo_rd_en stays 0 throughout and the FSM remains in IDLE.

Source files
------------

// File: rtl/factorial_core_if.sv
// Factorial core bus: input FIFO read port plus result handshake.
// The core side uses the slave modport; the driver/consumer uses master.
interface factorial_core_if;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic [63:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        overflow;
    logic        busy;

    modport master (
        output fifo_empty,
        output fifo_dout,
        output result_ready,
        input  fifo_rd_en,
        input  result,
        input  result_valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  fifo_empty,
        input  fifo_dout,
        input  result_ready,
        output fifo_rd_en,
        output result,
        output result_valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/factorial_core.sv
// Iterative 64-bit factorial engine fed from a FIFO.
// One multiply per cycle; operands above MAX_N report overflow.
module factorial_core #(
    parameter int unsigned MAX_N = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    factorial_core_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_acc;
    logic [31:0] r_cnt;
    logic        r_ovf;
    logic        r_armed;
    logic        w_rd;
    logic        w_small;
    logic        w_big;
    logic [63:0] w_prod;

    // r_armed keeps reads off until one full edge after reset release
    assign w_rd    = (r_state == S_IDLE) && r_armed && !bus.fifo_empty;
    assign w_small = bus.fifo_dout <= 32'd1;
    assign w_big   = bus.fifo_dout > 32'(MAX_N);
    assign w_prod  = r_acc * {32'd0, r_cnt};

    assign bus.fifo_rd_en   = w_rd;
    assign bus.result       = r_acc;
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.overflow     = r_ovf;
    assign bus.busy         = (r_state != S_IDLE);

    // State register and read-enable arming
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = w_rd ? S_WAIT : S_IDLE;
            S_WAIT: w_next = (w_small || w_big) ? S_DONE : S_CALC;
            S_CALC: w_next = (r_cnt <= 32'd2) ? S_DONE : S_CALC;
            S_DONE: w_next = bus.result_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and multiply-accumulate datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 64'd0;
            r_cnt <= 32'd0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= bus.fifo_dout;
                    r_acc <= w_big ? 64'd0 : 64'd1;
                    r_ovf <= w_big;
                end
                S_CALC: begin
                    r_acc <= w_prod;
                    r_cnt <= r_cnt - 32'd1;
                end
                default: begin
                    r_acc <= r_acc;
                    r_cnt <= r_cnt;
                    r_ovf <= r_ovf;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factorial_core.sv
// Scoreboard bench for factorial_core: FIFO model, random operands,
// random backpressure, directed corner cases and reset abandonment.
module tb_factorial_core;

    typedef struct {
        longint unsigned res;
        bit              ovf;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    factorial_core_if bus();

    factorial_core #(.MAX_N(20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          rd_q[$];
    logic [31:0] fifo_q[$];
    int          pass_cnt = 0;
    int          total = 0;
    int          cyc = 0;
    bit          rand_mode = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        total++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    function automatic longint unsigned ref_fact(input logic [31:0] n);
        longint unsigned r = 1;
        if (n > 32'd20) return 64'd0;
        for (int i = 2; i <= int'(n); i++) r = r * longint'(i);
        return r;
    endfunction

    function automatic int ref_lat(input logic [31:0] n);
        if (n >= 32'd2 && n <= 32'd20) return int'(n) + 1;
        return 2;
    endfunction

    task automatic push_op(input logic [31:0] n);
        exp_t e;
        e.res = ref_fact(n);
        e.ovf = (n > 32'd20);
        e.lat = ref_lat(n);
        fifo_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 &&
                !bus.busy && bus.fifo_empty)
                done = 1'b1;
        end
        if (!done) check("drain_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
        check({tag, "_valid"}, bus.result_valid, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Random result_ready during the random phase
    always @(posedge clk) begin
        #1;
        if (rand_mode) bus.result_ready = 1'($urandom_range(0, 1));
    end

    // FIFO model: pop on rd_en, data visible in the following cycle
    initial begin
        bit take;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = 32'd0;
        forever begin
            @(negedge clk);
            take = bus.fifo_rd_en;
            if (take) begin
                rd_q.push_back(cyc);
                check("rd_en_while_empty", bus.fifo_empty, 0);
            end
            @(posedge clk);
            #1;
            if (take && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: latency on valid rise, value on each handshake
    initial begin
        bit pv;
        bit hs_prev;
        int t;
        exp_t e;
        pv = 1'b0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) check("busy_after_handshake", bus.busy, 0);
                if (bus.result_valid && !pv) begin
                    if (rd_q.size() == 0 || exp_q.size() == 0)
                        check("valid_without_request", 1, 0);
                    else begin
                        t = rd_q.pop_front();
                        check("latency", longint'(cyc - t), longint'(exp_q[0].lat));
                    end
                end
                if (bus.result_valid && bus.result_ready) begin
                    if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("result", bus.result, e.res);
                        check("overflow", bus.overflow, e.ovf);
                    end
                end
                hs_prev = bus.result_valid && bus.result_ready;
                pv = bus.result_valid;
            end
        end
    end

    initial begin
        int bad;
        bit seen;
        logic [31:0] n;
        bus.result_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        push_op(32'd5);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rd_en_at_release", bus.fifo_rd_en, 0);
        wait_idle(100);

        push_op(32'd0);
        push_op(32'd1);
        wait_idle(100);

        push_op(32'd20);
        push_op(32'd21);
        wait_idle(100);

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.fifo_rd_en || bus.busy) bad++;
        end
        check("empty_idle_violations", bad, 0);

        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        push_op(32'd3);
        push_op(32'd7);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.result_valid;
        end
        check("bp_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rd_en", bus.fifo_rd_en, 0);
            check("bp_result", bus.result, 6);
            check("bp_valid", bus.result_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("read_after_handshake", bus.fifo_rd_en, 1);
        wait_idle(100);

        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) n = $urandom;
            else n = $urandom_range(0, 22);
            push_op(n);
        end
        wait_idle(5000);
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b1;

        push_op(32'd8);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.fifo_rd_en;
        end
        check("rst_test_rd_seen", seen, 1);
        repeat (4) @(negedge clk);
        check("rst_test_busy_calc", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_calc_reset");
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fifo_rd_en || bus.busy || bus.result_valid) bad++;
        end
        check("post_reset_quiet", bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
